// File: rtl/mux_pkg.sv
// Shared mux/demux definitions: channel count, select width, select type.
// Imported by the 8:1 merger and its arbiter; shared with the 1:8 demux.
package mux_pkg;

  localparam int CH_N  = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/rr_arbiter8.sv
// Combinational 8-way round-robin arbiter: rotate, priority-encode, add.
// Ports: req[7:0], ptr (last winner) -> grant_idx, any (some request).
module rr_arbiter8
  import mux_pkg::*;
(
  input  logic [CH_N-1:0] req,
  input  sel_t            ptr,
  output sel_t            grant_idx,
  output logic            any
);

  sel_t              start;
  sel_t              off;
  logic [2*CH_N-1:0] dbl;
  logic [CH_N-1:0]   rot;

  // Search begins just past the last winner; ptr itself is checked last.
  assign start = ptr + sel_t'(1);
  assign dbl   = {req, req};
  assign rot   = dbl[{1'b0, start} +: CH_N];

  always_comb begin
    off = '0;
    for (int i = CH_N - 1; i >= 0; i--) begin
      if (rot[i]) off = sel_t'(i);
    end
  end

  assign grant_idx = start + off;
  assign any       = |req;

endmodule

// File: rtl/mux8_1_arbiter.sv
// Round-robin 8:1 channel merger with registered valid/ready output.
// Ports: clk, rst, in_1..in_8, in_valid/in_ready, dataout, select, out_valid/out_ready.
module mux8_1_arbiter
  import mux_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_1,
  input  logic [DATA_W-1:0] in_2,
  input  logic [DATA_W-1:0] in_3,
  input  logic [DATA_W-1:0] in_4,
  input  logic [DATA_W-1:0] in_5,
  input  logic [DATA_W-1:0] in_6,
  input  logic [DATA_W-1:0] in_7,
  input  logic [DATA_W-1:0] in_8,
  input  logic [CH_N-1:0]   in_valid,
  output logic [CH_N-1:0]   in_ready,
  output logic [DATA_W-1:0] dataout,
  output sel_t              select,
  output logic              out_valid,
  input  logic              out_ready
);

  sel_t              ptr;
  sel_t              grant;
  logic              any;
  logic              load;
  logic [DATA_W-1:0] din [CH_N];

  assign din[0] = in_1;
  assign din[1] = in_2;
  assign din[2] = in_3;
  assign din[3] = in_4;
  assign din[4] = in_5;
  assign din[5] = in_6;
  assign din[6] = in_7;
  assign din[7] = in_8;

  rr_arbiter8 u_arb (
    .req       (in_valid),
    .ptr       (ptr),
    .grant_idx (grant),
    .any       (any)
  );

  // Output slot is free when empty or being drained this cycle.
  assign load = !out_valid || out_ready;

  always_comb begin
    in_ready = '0;
    if (!rst && load && any) in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      dataout   <= '0;
      select    <= '0;
      ptr       <= sel_t'(CH_N - 1);
    end else if (load) begin
      if (any) begin
        out_valid <= 1'b1;
        dataout   <= din[grant];
        select    <= grant;
        ptr       <= grant;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux8_1_arbiter.sv
// Scoreboard bench for mux8_1_arbiter: reference arbiter model plus
// directed test-plan sequences and a random phase.
module tb_mux8_1_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din [8];
  logic [7:0] in_valid;
  logic [7:0] in_ready;
  logic [3:0] dataout;
  logic [2:0] select;
  logic       out_valid;
  logic       out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] q[$];
  logic       m_ov;
  logic [2:0] m_ptr;
  logic       m_rst;

  always #5 clk = ~clk;

  mux8_1_arbiter #(.DATA_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_1      (din[0]),
    .in_2      (din[1]),
    .in_3      (din[2]),
    .in_4      (din[3]),
    .in_5      (din[4]),
    .in_6      (din[5]),
    .in_7      (din[6]),
    .in_8      (din[7]),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dataout   (dataout),
    .select    (select),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
               $time);
    end
  endtask

  function automatic logic [3:0] mgrant(input logic [7:0] v,
                                        input logic [2:0] p);
    logic [2:0] c;
    for (int i = 1; i <= 8; i++) begin
      c = p + i[2:0];
      if (v[c]) return {1'b1, c};
    end
    return 4'd0;
  endfunction

  task automatic check_outs();
    check("out_valid", {7'd0, out_valid}, {7'd0, m_ov});
    if (m_rst) begin
      check("rst_data", {4'd0, dataout}, 8'd0);
      check("rst_sel", {5'd0, select}, 8'd0);
    end else if (m_ov && q.size() > 0) begin
      check("data", {4'd0, dataout}, {4'd0, q[0][3:0]});
      check("sel", {5'd0, select}, {5'd0, q[0][6:4]});
    end
  endtask

  task automatic drive(input logic r, input logic [7:0] v,
                       input logic ord, input logic rnd);
    logic [3:0] g;
    logic       ld;
    logic [7:0] exp_rdy;
    @(negedge clk);
    check_outs();
    rst       = r;
    in_valid  = v;
    out_ready = ord;
    if (rnd) for (int k = 0; k < 8; k++) din[k] = 4'($urandom);
    #1;
    g  = mgrant(v, m_ptr);
    ld = !m_ov || ord;
    exp_rdy = (!r && ld && g[3]) ? (8'd1 << g[2:0]) : 8'd0;
    check("in_ready", in_ready, exp_rdy);
    @(posedge clk);
    if (r) begin
      q.delete();
      m_ov  = 1'b0;
      m_ptr = 3'd7;
      m_rst = 1'b1;
    end else begin
      m_rst = 1'b0;
      if (ld) begin
        if (m_ov && ord) void'(q.pop_front());
        if (g[3]) begin
          q.push_back({g[2:0], din[g[2:0]]});
          m_ptr = g[2:0];
          m_ov  = 1'b1;
        end else begin
          m_ov = 1'b0;
        end
      end
    end
  endtask

  task automatic expect_out(input logic [2:0] s, input logic [3:0] d);
    #1;
    check("exp_ov", {7'd0, out_valid}, 8'd1);
    check("exp_sel", {5'd0, select}, {5'd0, s});
    check("exp_data", {4'd0, dataout}, {4'd0, d});
  endtask

  task automatic set_ramp();
    for (int k = 0; k < 8; k++) din[k] = 4'(k + 1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 8'h00;
    out_ready = 1'b0;
    m_ov = 1'b0;
    m_ptr = 3'd7;
    m_rst = 1'b0;
    set_ramp();

    // reset with everyone requesting, then first grant is channel 0
    drive(1'b1, 8'hFF, 1'b1, 1'b0);
    drive(1'b1, 8'hFF, 1'b1, 1'b0);
    drive(1'b0, 8'hFF, 1'b1, 1'b0);
    expect_out(3'd0, 4'd1);

    // single requester
    din[2] = 4'd12;
    drive(1'b0, 8'b0000_0100, 1'b1, 1'b0);
    expect_out(3'd2, 4'd12);
    set_ramp();

    // full rotation from a fresh pointer
    drive(1'b1, 8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 8'hFF, 1'b1, 1'b0);
      expect_out(3'(i % 8), 4'((i % 8) + 1));
    end

    // backpressure while select=3 is presented
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 8'hFF, 1'b1, 1'b0);
      expect_out(3'(i), 4'(i + 1));
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'hFF, 1'b0, 1'b0);
      expect_out(3'd3, 4'd4);
    end
    drive(1'b0, 8'hFF, 1'b1, 1'b0);
    expect_out(3'd4, 4'd5);

    // two requesters alternate, lone requester served every cycle
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'b0010_0001, 1'b1, 1'b0);
      expect_out((i % 2 == 0) ? 3'd5 : 3'd0, (i % 2 == 0) ? 4'd6 : 4'd1);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h40, 1'b1, 1'b0);
      expect_out(3'd6, 4'd7);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);

    // reset while holding a word under backpressure
    drive(1'b0, 8'hFF, 1'b1, 1'b0);
    drive(1'b0, 8'hFF, 1'b0, 1'b0);
    drive(1'b1, 8'hFF, 1'b0, 1'b0);
    #1;
    check("mid_rst_ov", {7'd0, out_valid}, 8'd0);
    drive(1'b0, 8'hFF, 1'b1, 1'b0);
    expect_out(3'd0, 4'd1);

    // random traffic against the model
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 49) == 0), 8'($urandom),
            ($urandom_range(0, 3) != 0), 1'b1);
    end

    @(negedge clk);
    check_outs();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
